// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues word reads to a 1-cycle synchronous instruction ROM,
// buffers returned words in a 2-entry FIFO and presents them to decode on a valid/ready link.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clock,
   input  logic        reset,
   output logic        irom_req,
   output logic [31:0] irom_addr,
   input  logic [31:0] irom_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic [31:0] snpc,
   output logic        valid_next,
   input  logic        ready_next
);

   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

   // Fetch PC is always word aligned, so only the word index is kept.
   logic [29:0] r_fetch_word;
   logic [1:0]  r_cnt;
   logic        r_inflight;
   logic [31:0] r_req_addr;
   logic        r_head;
   logic [31:0] r_fifo_inst [2];
   logic [31:0] r_fifo_pc   [2];

   logic        w_pop;
   logic        w_push;
   logic        w_req;
   logic        w_tail;
   logic [2:0]  w_occupancy;
   logic [1:0]  w_cnt_next;
   logic [31:0] w_redirect_addr;
   logic [31:0] w_fetch_addr;

   assign w_redirect_addr = redirect_pc & ALIGN_MASK;
   assign w_fetch_addr    = {r_fetch_word, 2'b00};

   assign valid_next = (r_cnt != 2'd0);
   assign w_pop      = valid_next & ready_next;
   assign w_push     = r_inflight & ~redirect_valid;

   // Slots already claimed next cycle: entries staying plus the word in flight.
   assign w_occupancy = {1'b0, r_cnt} - {2'b00, w_pop} + {2'b00, r_inflight};
   assign w_req       = ~reset & (redirect_valid | (w_occupancy < 3'd2));
   assign irom_req    = w_req;
   assign irom_addr   = redirect_valid ? w_redirect_addr : w_fetch_addr;

   // Tail slot is head + cnt modulo 2; with cnt=2 a push only happens alongside a pop.
   assign w_tail     = r_head ^ r_cnt[0];
   assign w_cnt_next = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

   assign inst = valid_next ? r_fifo_inst[r_head] : NOP_INST;
   assign pc   = valid_next ? r_fifo_pc[r_head]   : 32'h0000_0000;
   assign snpc = pc + 32'd4;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would create order-dependent simulation races.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_fetch_word <= RESET_PC[31:2];
         r_req_addr   <= RESET_PC & ALIGN_MASK;
         r_cnt        <= 2'd0;
         r_inflight   <= 1'b0;
         r_head       <= 1'b0;
      end else if (redirect_valid) begin
         // Redirect wins over pop, push and the normal request in the same cycle.
         r_fetch_word <= w_redirect_addr[31:2] + 30'd1;
         r_req_addr   <= w_redirect_addr;
         r_cnt        <= 2'd0;
         r_inflight   <= 1'b1;
         r_head       <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_next;
         r_head     <= r_head ^ w_pop;
         r_inflight <= w_req;
         if (w_req) begin
            r_fetch_word <= r_fetch_word + 30'd1;
            r_req_addr   <= w_fetch_addr;
         end
      end
   end

   // NOTE: FIFO storage is deliberately not reset; r_cnt gates every read, so stale
   // contents are never visible and the array can map to plain flops or RAM.
   always_ff @(posedge clock) begin
      if (w_push && !reset) begin
         r_fifo_inst[w_tail] <= irom_rdata;
         r_fifo_pc[w_tail]   <= r_req_addr;
      end
   end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit for the RV32I pipeline. It is the upstream producer on the fetch->decode valid/ready link.
- Holds the architectural fetch PC and issues word reads to a synchronous instruction ROM with 1-cycle latency.
- Buffers returned words in a 2-entry FIFO and presents inst/pc/snpc to decode.
- Accepts redirects (branch, jump, ecall, mret) from execute.

Parameters:
- RESET_PC, 32'h8000_0000, fetch address after reset
- NOP_INST, 32'h0000_0013, value driven on inst when FIFO is empty

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- irom_req  output  1  read request this cycle
- irom_addr  output  32  byte address of request, bits[1:0] always 2'b00
- irom_rdata  input  32  word for the request issued in the previous cycle
- redirect_valid  input  1  redirect fetch stream this cycle
- redirect_pc  input  32  redirect target address
- inst  output  32  FIFO head instruction
- pc  output  32  FIFO head address
- snpc  output  32  pc + 4
- valid_next  output  1  FIFO head valid
- ready_next  input  1  decode accepts head this cycle

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high.
- State:
  - fetch_pc[31:0]: next address to request.
  - cnt[1:0]: FIFO occupancy, 0..2.
  - inflight: a request was issued last cycle.
  - FIFO: 2 entries of {inst, pc}.
- Reset (while reset=1, taking effect at the clock edge):
  - fetch_pc=RESET_PC, cnt=0, inflight=0.
  - Outputs: irom_req=0, valid_next=0, inst=NOP_INST, pc=0, snpc=4.
- Handshakes:
  - pop = valid_next & ready_next.
  - valid_next = (cnt!=0), driven from registers only, with no combinational path from ready_next or irom_rdata.
  - inst/pc/snpc are held stable while valid_next=1 and ready_next=0.
- Return path:
  - If inflight=1 and redirect_valid=0, push {irom_rdata, address of the returning request} at the clock edge.
- Request rule:
  - irom_req=1 when !reset and (cnt - pop + inflight) < 2, where pop is evaluated this cycle. A returning word always has a slot, so overflow is impossible.
  - On a request: irom_addr = {fetch_pc[31:2],2'b00}; fetch_pc <= fetch_pc+4; inflight<=1. Otherwise inflight<=0.
- Redirect (redirect_valid=1 in cycle T) has priority over every other event in T:
  - FIFO cleared, cnt<=0.
  - Word returning in T is discarded.
  - A pop in T has no effect on state.
  - irom_req=1 with irom_addr={redirect_pc[31:2],2'b00}; fetch_pc<=redirect_pc+4 (low bits cleared); inflight<=1.
  - Target appears with valid_next=1 in T+2.
  - valid_next/inst in cycle T still show the pre-redirect head; decode squashes it itself.
- Misaligned redirect_pc: bits[1:0] silently cleared; pc output is always word-aligned.
- Simultaneous push and pop:
  - cnt unchanged; head advances; new word written to the tail.
  - With cnt=1, the incoming word becomes head next cycle.
- Throughput: with ready_next=1 continuously, one instruction per cycle.
- Latency: 2 cycles from request to valid_next.
- Back-pressure: with ready_next=0, fetch stops after FIFO full (cnt=2, inflight=0). No word is lost or duplicated.
- Arithmetic: all PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Reset mid-operation: discards FIFO and inflight; the first request after reset deasserts targets RESET_PC.

Test Plan:
- Reset release, ready_next=1 -> irom_req=1 with addr 8000_0000 in cycle 0. valid_next=1 with pc=8000_0000, snpc=8000_0004 in cycle 2. Then pc increments by 4 every cycle.
- Streaming, then ready_next=0 for 4 cycles -> irom_req drops once cnt=2. inst/pc stay frozen. On ready_next=1, pcs continue contiguous with no gap or duplicate.
- Redirect to 8000_0100 while cnt=2 and ready_next=0 -> FIFO flushed. irom_addr=8000_0100 in the same cycle. valid_next=1 with pc=8000_0100 two cycles later. The word returned in the redirect cycle never appears.
- Redirect to 8000_0102 -> irom_addr=8000_0100, pc output 8000_0100.
- Back-to-back redirects in cycles T and T+1 (targets A, B) -> only B's stream appears, from T+3. A is never presented.
- Reset asserted for 1 cycle mid-stream with cnt=2 -> valid_next=0 and inst=0000_0013 next cycle. Fetch restarts at 8000_0000.
- Fetch at FFFF_FFFC -> following pc is 0000_0000.
